// File: rtl/shared_reg_pkg.sv
// Shared types and default constants for the shared register arbiter.
// Optional build macro: SHARED_REG_FIXED_PRIO_EN (see rr_pick).
package shared_reg_pkg;

  localparam int unsigned DefNumReq     = 4;
  localparam int unsigned DefDataW      = 8;
  localparam int unsigned DefHoldCycles = 2;
  localparam int unsigned GuardCntW     = 4;

  typedef enum logic [1:0] {
    StIdle,
    StWrite,
    StGuard
  } state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational requester picker: round-robin starting after start_i, or fixed
// priority (lowest index wins) when SHARED_REG_FIXED_PRIO_EN is defined.
module rr_pick
  import shared_reg_pkg::*;
#(
  parameter int unsigned NUM_REQ = DefNumReq
) (
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [$clog2(NUM_REQ)-1:0] start_i,
  output logic [NUM_REQ-1:0]         pick_o,
  output logic [$clog2(NUM_REQ)-1:0] pick_idx_o,
  output logic                       valid_o
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);

  logic [IdxW:0]   offset;
  logic [IdxW:0]   sum;
  logic [IdxW-1:0] idx;

  always_comb begin
`ifdef SHARED_REG_FIXED_PRIO_EN
    offset = '0;
`else
    offset = {1'b0, start_i} + (IdxW + 1)'(1);
`endif
    sum        = '0;
    idx        = '0;
    pick_o     = '0;
    pick_idx_o = '0;
    valid_o    = 1'b0;
    // Scan farthest-first so the candidate nearest to the offset is written last and wins.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      sum = offset + (IdxW + 1)'(i);
      if (sum >= (IdxW + 1)'(NUM_REQ)) begin
        sum = sum - (IdxW + 1)'(NUM_REQ);
      end
      idx = sum[IdxW-1:0];
      if (req_i[idx]) begin
        pick_o      = '0;
        pick_o[idx] = 1'b1;
        pick_idx_o  = idx;
        valid_o     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Arbiter and write sequencer for a single shared register: IDLE -> WRITE -> GUARD.
// Build macro SHARED_REG_FIXED_PRIO_EN switches arbitration to fixed priority.
module shared_reg_arbiter
  import shared_reg_pkg::*;
#(
  parameter int unsigned NUM_REQ     = DefNumReq,
  parameter int unsigned DATA_W      = DefDataW,
  parameter int unsigned HOLD_CYCLES = DefHoldCycles
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*DATA_W-1:0]   wdata,
  output logic [NUM_REQ-1:0]          gnt,
  output logic [$clog2(NUM_REQ)-1:0]  owner,
  output logic [DATA_W-1:0]           q,
  output logic                        q_valid,
  output logic                        busy
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);

  state_e                 state_q, state_d;
  logic [IdxW-1:0]        owner_q, owner_d;
  logic [DATA_W-1:0]      q_q, q_d;
  logic                   q_valid_q, q_valid_d;
  logic [GuardCntW-1:0]   cnt_q, cnt_d;
  logic [NUM_REQ-1:0]     gnt_q, gnt_d;
  logic                   busy_q, busy_d;

  logic [NUM_REQ-1:0]     pick_oh;
  logic [IdxW-1:0]        pick_idx;
  logic                   pick_valid;

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .req_i      (req),
    .start_i    (owner_q),
    .pick_o     (pick_oh),
    .pick_idx_o (pick_idx),
    .valid_o    (pick_valid)
  );

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    q_d       = q_q;
    q_valid_d = q_valid_q;
    cnt_d     = cnt_q;
    gnt_d     = '0;
    busy_d    = busy_q;
    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          state_d = StWrite;
          owner_d = pick_idx;
          gnt_d   = pick_oh;
          busy_d  = 1'b1;
        end
      end
      StWrite: begin
        q_d       = wdata[owner_q*DATA_W +: DATA_W];
        q_valid_d = 1'b1;
        if (HOLD_CYCLES != 0) begin
          state_d = StGuard;
          // Counter runs HOLD_CYCLES-1 down to 0, one GUARD cycle per value.
          cnt_d   = GuardCntW'(HOLD_CYCLES - 1);
          busy_d  = 1'b1;
        end else begin
          state_d = StIdle;
          busy_d  = 1'b0;
        end
      end
      StGuard: begin
        if (cnt_q == '0) begin
          state_d = StIdle;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - GuardCntW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      owner_q   <= IdxW'(NUM_REQ - 1);
      q_q       <= '0;
      q_valid_q <= 1'b0;
      cnt_q     <= '0;
      gnt_q     <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      q_q       <= q_d;
      q_valid_q <= q_valid_d;
      cnt_q     <= cnt_d;
      gnt_q     <= gnt_d;
      busy_q    <= busy_d;
    end
  end

  assign gnt     = gnt_q;
  assign owner   = owner_q;
  assign q       = q_q;
  assign q_valid = q_valid_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Directed bench for shared_reg_arbiter: default instance plus a HOLD_CYCLES=0 instance.
// Expectations follow SHARED_REG_FIXED_PRIO_EN when that macro is defined.
module tb_shared_reg_arbiter;

`ifdef SHARED_REG_FIXED_PRIO_EN
  localparam bit Fixed = 1'b1;
`else
  localparam bit Fixed = 1'b0;
`endif

  logic        clk;
  logic        rst;

  logic [3:0]  req_a;
  logic [31:0] wdata_a;
  logic [3:0]  gnt_a;
  logic [1:0]  owner_a;
  logic [7:0]  q_a;
  logic        q_valid_a;
  logic        busy_a;

  logic [3:0]  req_b;
  logic [31:0] wdata_b;
  logic [3:0]  gnt_b;
  logic [1:0]  owner_b;
  logic [7:0]  q_b;
  logic        q_valid_b;
  logic        busy_b;

  int tests;
  int fails;
  int e;

  shared_reg_arbiter #(
    .NUM_REQ     (4),
    .DATA_W      (8),
    .HOLD_CYCLES (2)
  ) dut_a (
    .clk     (clk),
    .rst     (rst),
    .req     (req_a),
    .wdata   (wdata_a),
    .gnt     (gnt_a),
    .owner   (owner_a),
    .q       (q_a),
    .q_valid (q_valid_a),
    .busy    (busy_a)
  );

  shared_reg_arbiter #(
    .NUM_REQ     (4),
    .DATA_W      (8),
    .HOLD_CYCLES (0)
  ) dut_b (
    .clk     (clk),
    .rst     (rst),
    .req     (req_b),
    .wdata   (wdata_b),
    .gnt     (gnt_b),
    .owner   (owner_b),
    .q       (q_b),
    .q_valid (q_valid_b),
    .busy    (busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  initial begin
    tests   = 0;
    fails   = 0;
    rst     = 1'b0;
    req_a   = 4'b1111;
    wdata_a = {8'h13, 8'h12, 8'h11, 8'h10};
    req_b   = 4'b0000;
    wdata_b = {8'h24, 8'h23, 8'h22, 8'h21};

    // Reset held with all requests active
    repeat (3) nxt();
    chk("rst_gnt", gnt_a, 4'b0000);
    chk("rst_q", q_a, 8'h00);
    chk("rst_q_valid", q_valid_a, 1'b0);
    chk("rst_busy", busy_a, 1'b0);
    chk("rst_owner", owner_a, 2'd3);
    chk("rst_owner_b", owner_b, 2'd3);

    // Release: first grant goes to requester 0, then fairness rotation
    rst = 1'b1;
    nxt();
    for (int k = 0; k < 5; k++) begin
      e = Fixed ? 0 : k % 4;
      chk("fair_gnt", gnt_a, 32'(1 << e));
      chk("fair_owner", owner_a, 32'(e));
      chk("fair_busy_write", busy_a, 1'b1);
      if (k == 4) req_a = 4'b0000;
      nxt();
      chk("fair_q", q_a, 32'(8'h10 + e));
      chk("fair_q_valid", q_valid_a, 1'b1);
      chk("fair_gnt_guard", gnt_a, 4'b0000);
      chk("fair_busy_guard1", busy_a, 1'b1);
      nxt();
      chk("fair_busy_guard2", busy_a, 1'b1);
      nxt();
      chk("fair_busy_idle", busy_a, 1'b0);
      nxt();
    end
    chk("fair_end_gnt", gnt_a, 4'b0000);
    chk("fair_end_busy", busy_a, 1'b0);
    chk("fair_end_q", q_a, 8'h10);

    // Single write from requester 2
    wdata_a[23:16] = 8'hA5;
    req_a = 4'b0100;
    nxt();
    chk("single_gnt", gnt_a, 4'b0100);
    chk("single_owner", owner_a, 2'd2);
    chk("single_busy1", busy_a, 1'b1);
    chk("single_q_old", q_a, 8'h10);
    req_a = 4'b0000;
    nxt();
    chk("single_q", q_a, 8'hA5);
    chk("single_q_valid", q_valid_a, 1'b1);
    chk("single_gnt_off", gnt_a, 4'b0000);
    chk("single_busy2", busy_a, 1'b1);
    nxt();
    chk("single_busy3", busy_a, 1'b1);
    nxt();
    chk("single_idle_busy", busy_a, 1'b0);
    nxt();
    chk("single_no_regrant", gnt_a, 4'b0000);
    chk("single_q_hold", q_a, 8'hA5);

    // Requester 1 drops its request during requester 0's guard interval
    wdata_a[7:0]  = 8'h5A;
    wdata_a[15:8] = 8'h77;
    req_a = 4'b0011;
    nxt();
    chk("drop_gnt0", gnt_a, 4'b0001);
    req_a = 4'b0010;
    nxt();
    chk("drop_q0", q_a, 8'h5A);
    req_a = 4'b0000;
    nxt();
    nxt();
    for (int k = 0; k < 3; k++) begin
      nxt();
      chk("drop_no_gnt", gnt_a, 4'b0000);
      chk("drop_no_busy", busy_a, 1'b0);
    end
    chk("drop_q_kept", q_a, 8'h5A);

    // Reset asserted in the middle of a WRITE cycle
    wdata_a[31:24] = 8'hFF;
    req_a = 4'b1000;
    nxt();
    chk("rstmid_gnt", gnt_a, 4'b1000);
    rst = 1'b0;
    #1;
    chk("rstmid_q", q_a, 8'h00);
    chk("rstmid_q_valid", q_valid_a, 1'b0);
    chk("rstmid_gnt_off", gnt_a, 4'b0000);
    chk("rstmid_busy", busy_a, 1'b0);
    chk("rstmid_owner", owner_a, 2'd3);
    req_a = 4'b0000;
    nxt();
    rst = 1'b1;
    repeat (4) nxt();
    chk("rstmid_after_q", q_a, 8'h00);
    chk("rstmid_after_q_valid", q_valid_a, 1'b0);
    chk("rstmid_after_gnt", gnt_a, 4'b0000);

    // HOLD_CYCLES=0 instance: back-to-back grants every two cycles
    req_b = 4'b0011;
    for (int k = 0; k < 4; k++) begin
      e = Fixed ? 0 : k % 2;
      nxt();
      chk("hold0_gnt", gnt_b, 32'(1 << e));
      chk("hold0_owner", owner_b, 32'(e));
      chk("hold0_busy", busy_b, 1'b1);
      nxt();
      chk("hold0_gnt_off", gnt_b, 4'b0000);
      chk("hold0_q", q_b, 32'(8'h21 + e));
      chk("hold0_q_valid", q_valid_b, 1'b1);
    end
    req_b = 4'b0000;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
